// File: rtl/peripheral_timer_pkg.sv
//==============================================================================
// peripheral_timer_pkg : shared constants for the timer peripheral
// Rev 1.0
//==============================================================================
`default_nettype none

package peripheral_timer_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

    // Byte offsets from the base address
    localparam logic [4:0] OFF_TH      = 5'h00;
    localparam logic [4:0] OFF_TL      = 5'h04;
    localparam logic [4:0] OFF_TCON    = 5'h08;
    localparam logic [4:0] OFF_LED     = 5'h0C;
    localparam logic [4:0] OFF_SWITCH  = 5'h10;
    localparam logic [4:0] OFF_DIGI    = 5'h14;
    localparam logic [4:0] OFF_SYSTICK = 5'h18;

    localparam int unsigned TCON_EN     = 0;
    localparam int unsigned TCON_IRQEN  = 1;
    localparam int unsigned TCON_STATUS = 2;

    // Word select within the window for a byte offset
    function automatic logic [2:0] reg_sel(input logic [4:0] off);
        return off[4:2];
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
//==============================================================================
// sync_2ff : two-flop synchroniser for asynchronous inputs
// Rev 1.0
//==============================================================================
`default_nettype none

module sync_2ff #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] stage2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= d;
            stage2_q <= stage1_q;
        end
    end

    assign q = stage2_q;

endmodule

`default_nettype wire

// File: rtl/peripheral_timer.sv
//==============================================================================
// peripheral_timer : bus-mapped reload timer, systick, LED/7-seg, switch input
// Rev 1.0
//==============================================================================
`default_nettype none

module peripheral_timer
    import peripheral_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [7:0]  led,
    input  logic [7:0]  switch,
    output logic [11:0] digi
);

    localparam logic [2:0] SEL_TH      = reg_sel(OFF_TH);
    localparam logic [2:0] SEL_TL      = reg_sel(OFF_TL);
    localparam logic [2:0] SEL_TCON    = reg_sel(OFF_TCON);
    localparam logic [2:0] SEL_LED     = reg_sel(OFF_LED);
    localparam logic [2:0] SEL_SWITCH  = reg_sel(OFF_SWITCH);
    localparam logic [2:0] SEL_DIGI    = reg_sel(OFF_DIGI);
    localparam logic [2:0] SEL_SYSTICK = reg_sel(OFF_SYSTICK);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  led_q, led_d;
    logic [11:0] digi_q, digi_d;
    logic [31:0] systick_q, systick_d;
    logic [7:0]  switch_sync;

    logic        hit;
    logic [2:0]  sel;
    logic        wr_en;
    logic        overflow;
    logic        unused_addr_bits;

    assign hit              = (addr[31:5] == BASE_ADDR[31:5]);
    assign sel              = addr[4:2];
    assign wr_en            = wr && hit;
    assign overflow         = tcon_q[TCON_EN] && (tl_q == 32'hFFFF_FFFF);
    assign unused_addr_bits = ^addr[1:0];

    sync_2ff #(
        .WIDTH (8)
    ) u_switch_sync (
        .clk   (clk),
        .reset (reset),
        .d     (switch),
        .q     (switch_sync)
    );

    always_comb begin
        th_d      = th_q;
        tl_d      = tl_q;
        tcon_d    = tcon_q;
        led_d     = led_q;
        digi_d    = digi_q;
        systick_d = systick_q + 32'd1;

        // Reload reads th_q, so a TH store in the overflow cycle applies next time
        if (tcon_q[TCON_EN]) begin
            tl_d = overflow ? th_q : tl_q + 32'd1;
        end
        if (overflow && tcon_q[TCON_IRQEN]) begin
            tcon_d[TCON_STATUS] = 1'b1;
        end

        if (wr_en) begin
            case (sel)
                SEL_TH: th_d = wdata;
                SEL_TL: tl_d = wdata;
                SEL_TCON: begin
                    tcon_d[TCON_EN]     = wdata[TCON_EN];
                    tcon_d[TCON_IRQEN]  = wdata[TCON_IRQEN];
                    // A coincident overflow still latches status so no interrupt is lost
                    tcon_d[TCON_STATUS] = wdata[TCON_STATUS] | (overflow & wdata[TCON_IRQEN]);
                end
                SEL_LED:  led_d  = wdata[7:0];
                SEL_DIGI: digi_d = wdata[11:0];
                default:  ;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        if (rd && hit) begin
            case (sel)
                SEL_TH:      rdata = th_q;
                SEL_TL:      rdata = tl_q;
                SEL_TCON:    rdata = {29'd0, tcon_q};
                SEL_LED:     rdata = {24'd0, led_q};
                SEL_SWITCH:  rdata = {24'd0, switch_sync};
                SEL_DIGI:    rdata = {20'd0, digi_q};
                SEL_SYSTICK: rdata = systick_q;
                default:     rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q      <= '0;
            tl_q      <= '0;
            tcon_q    <= '0;
            led_q     <= '0;
            digi_q    <= '0;
            systick_q <= '0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            led_q     <= led_d;
            digi_q    <= digi_d;
            systick_q <= systick_d;
        end
    end

    assign irq  = tcon_q[TCON_IRQEN] & tcon_q[TCON_STATUS];
    assign led  = led_q;
    assign digi = digi_q;

endmodule

`default_nettype wire

// File: tb/tb_peripheral_timer.sv
//==============================================================================
// tb_peripheral_timer : directed and random checks against a behavioural model
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_peripheral_timer;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    logic [31:0] rdata;
    logic        irq;
    logic [7:0]  led;
    logic [7:0]  sw;
    logic [11:0] digi;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_th, m_tl, m_sys;
    logic        m_en, m_ien, m_st;
    logic [7:0]  m_led, m_sw1, m_sw2;
    logic [11:0] m_digi;

    peripheral_timer #(
        .BASE_ADDR (BASE)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .wdata  (wdata),
        .rd     (rd),
        .wr     (wr),
        .rdata  (rdata),
        .irq    (irq),
        .led    (led),
        .switch (sw),
        .digi   (digi)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_th = 0; m_tl = 0; m_sys = 0;
        m_en = 0; m_ien = 0; m_st = 0;
        m_led = 0; m_sw1 = 0; m_sw2 = 0; m_digi = 0;
    endtask

    function automatic logic in_window(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd32);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] off;
        if (!in_window(a)) return 32'd0;
        off = (a - BASE) & ~32'd3;
        case (off)
            32'h00:  return m_th;
            32'h04:  return m_tl;
            32'h08:  return {29'd0, m_st, m_ien, m_en};
            32'h0C:  return {24'd0, m_led};
            32'h10:  return {24'd0, m_sw2};
            32'h14:  return {20'd0, m_digi};
            32'h18:  return m_sys;
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model by one edge using the inputs currently driven, then clock
    task automatic tick();
        logic        ovf, whit, n_st;
        logic [31:0] off, n_tl;
        ovf  = m_en && (m_tl == 32'hFFFF_FFFF);
        whit = wr && in_window(addr);
        off  = (addr - BASE) & ~32'd3;
        n_tl = m_tl;
        n_st = m_st;
        if (m_en) n_tl = ovf ? m_th : m_tl + 32'd1;
        if (ovf && m_ien) n_st = 1'b1;
        if (whit && off == 32'h08) begin
            n_st  = wdata[2] | (ovf & wdata[1]);
            m_en  = wdata[0];
            m_ien = wdata[1];
        end
        if (whit && off == 32'h04) n_tl   = wdata;
        if (whit && off == 32'h00) m_th   = wdata;
        if (whit && off == 32'h0C) m_led  = wdata[7:0];
        if (whit && off == 32'h14) m_digi = wdata[11:0];
        m_tl  = n_tl;
        m_st  = n_st;
        m_sys = m_sys + 32'd1;
        m_sw2 = m_sw1;
        m_sw1 = sw;
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr = 1'b1; rd = 1'b0;
        tick();
        wr = 1'b0;
    endtask

    // Read checked against the model and against an explicit expected constant
    task automatic rd_const(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a; rd = 1'b1;
        #1;
        chk({tag, "_model"}, rdata, m_read(a));
        chk(tag, rdata, exp);
        rd = 1'b0;
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        chk({tag, "_model"}, 32'(irq), 32'(m_ien & m_st));
        chk(tag, 32'(irq), 32'(exp));
    endtask

    logic [31:0] a;
    int unsigned r;

    initial begin
        reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; sw = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        for (int i = 0; i < 8; i++) rd_const("reset_read", BASE + 32'(i * 4), 32'd0);
        chk_irq("reset_irq", 1'b0);
        chk("reset_led", 32'(led), 32'd0);
        chk("reset_digi", 32'(digi), 32'd0);
        addr = BASE; rd = 1'b0;
        #1;
        chk("reset_rd_low", rdata, 32'd0);

        // Overflow, reload and interrupt
        write(BASE + 32'h00, 32'hFFFF_FFF0);
        write(BASE + 32'h04, 32'hFFFF_FFFE);
        write(BASE + 32'h08, 32'd3);
        tick();
        rd_const("tl_pre_ovf", BASE + 32'h04, 32'hFFFF_FFFF);
        chk_irq("irq_pre_ovf", 1'b0);
        tick();
        rd_const("tl_reload", BASE + 32'h04, 32'hFFFF_FFF0);
        chk_irq("irq_rise", 1'b1);
        rd_const("tcon_status", BASE + 32'h08, 32'd7);
        write(BASE + 32'h08, 32'd3);
        chk_irq("irq_ack", 1'b0);
        rd_const("tcon_ack", BASE + 32'h08, 32'd3);

        // TCON write coincident with overflow
        write(BASE + 32'h04, 32'hFFFF_FFFF);
        rd_const("tl_write_wins", BASE + 32'h04, 32'hFFFF_FFFF);
        write(BASE + 32'h08, 32'd3);
        rd_const("tcon_set_wins", BASE + 32'h08, 32'd7);
        chk_irq("irq_set_wins", 1'b1);
        write(BASE + 32'h08, 32'd3);
        chk_irq("irq_ack2", 1'b0);

        // TH write coincident with overflow reloads the old TH
        write(BASE + 32'h04, 32'hFFFF_FFFF);
        write(BASE + 32'h00, 32'h0000_1234);
        rd_const("tl_old_th", BASE + 32'h04, 32'hFFFF_FFF0);
        rd_const("th_new", BASE + 32'h00, 32'h0000_1234);
        write(BASE + 32'h08, 32'd3);
        chk_irq("irq_ack3", 1'b0);

        // Overflow with irq_en clear
        write(BASE + 32'h08, 32'd1);
        write(BASE + 32'h04, 32'hFFFF_FFFF);
        tick();
        rd_const("tl_reload_noirq", BASE + 32'h04, 32'h0000_1234);
        chk_irq("irq_disabled", 1'b0);
        rd_const("tcon_noirq", BASE + 32'h08, 32'd1);

        // Switch synchroniser and read-only registers
        sw = 8'hA5;
        tick();
        rd_const("switch_1edge", BASE + 32'h10, 32'd0);
        tick();
        rd_const("switch_2edge", BASE + 32'h10, 32'h0000_00A5);
        write(BASE + 32'h10, 32'hFFFF_FFFF);
        write(BASE + 32'h18, 32'd0);
        rd_const("switch_ro", BASE + 32'h10, 32'h0000_00A5);
        rd_const("systick_ro", BASE + 32'h18, m_sys);

        // LED / DIGI, decode boundaries
        write(BASE + 32'h0C, 32'hFFFF_FF5A);
        write(BASE + 32'h14, 32'hFFFF_FABC);
        rd_const("led_read", BASE + 32'h0C, 32'h0000_005A);
        rd_const("digi_read", BASE + 32'h14, 32'h0000_0ABC);
        chk("led_port", 32'(led), 32'h5A);
        chk("digi_port", 32'(digi), 32'hABC);
        rd_const("unmapped_1c", BASE + 32'h1C, 32'd0);
        rd_const("outside_20", BASE + 32'h20, 32'd0);
        write(BASE + 32'h20, 32'h5555_5555);
        rd_const("no_alias_th", BASE + 32'h00, 32'h0000_1234);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 90)      a = BASE + (32'($urandom_range(0, 7)) << 2);
            else if (r < 95) a = BASE + 32'h20 + (32'($urandom_range(0, 7)) << 2);
            else             a = $urandom;
            a = a | 32'($urandom_range(0, 3));
            addr  = a;
            rd    = 1'($urandom_range(0, 1));
            wr    = ($urandom_range(0, 3) == 0);
            sw    = 8'($urandom);
            wdata = $urandom;
            if (((a - BASE) & ~32'd3) == 32'h04 && $urandom_range(0, 1) == 1)
                wdata = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            #1;
            chk("rand_rdata", rdata, rd ? m_read(a) : 32'd0);
            chk("rand_irq", 32'(irq), 32'(m_ien & m_st));
            chk("rand_led", 32'(led), 32'(m_led));
            chk("rand_digi", 32'(digi), 32'(m_digi));
            tick();
        end
        wr = 1'b0; rd = 1'b0;

        // Reset in the middle of counting with an interrupt pending
        write(BASE + 32'h08, 32'd0);
        write(BASE + 32'h00, 32'd5);
        write(BASE + 32'h04, 32'hFFFF_FFFF);
        write(BASE + 32'h08, 32'd3);
        tick();
        rd_const("tl_before_reset", BASE + 32'h04, 32'd5);
        chk_irq("irq_before_reset", 1'b1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        rd_const("tl_async_reset", BASE + 32'h04, 32'd0);
        chk_irq("irq_async_reset", 1'b0);
        #1;
        reset = 1'b0;
        tick();
        rd_const("tl_stopped", BASE + 32'h04, 32'd0);
        rd_const("tcon_cleared", BASE + 32'h08, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
